// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_e    : responder FSM states
//   NUM_LANES  : byte lanes per data word
//   ADDR_LSB   : byte-address bits below the word index
//   CNT_W      : width of the wait-state counter (LATENCY 0..15)
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned ADDR_LSB  = 2;
    localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/dmem_ram_1rw.sv
// Single-port word RAM with per-byte write enables and a registered read port.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (read register only; array is not reset)
//   en_i     : perform an access this edge (updates the read register)
//   we_i     : write the enabled lanes of wdata_i into word idx_i
//   rd_i     : load the addressed word into the read register; otherwise it loads 0
//   be_i     : byte-lane write enables
//   idx_i    : word index
//   wdata_i  : write data
//   rdata_o  : registered read data
module dmem_ram_1rw
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic                     rd_i,
    input  logic [NUM_LANES-1:0]     be_i,
    input  logic [IDX_W-1:0]         idx_i,
    input  logic [8*NUM_LANES-1:0]   wdata_i,
    output logic [8*NUM_LANES-1:0]   rdata_o
);

    logic [8*NUM_LANES-1:0] mem_q [DEPTH_WORDS];
    logic [8*NUM_LANES-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Stores and faulting accesses return zero, so the register is
    // reloaded on every access rather than only on loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= rd_i ? mem_q[idx_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port.
// One request at a time, LATENCY wait states, then a held response.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : request present            req_ready : can accept this cycle
//   req_addr   : byte address               req_we    : 1 = store, 0 = load
//   req_wdata  : store data                 req_be    : store byte-lane enables
//   rsp_valid  : response present           rsp_ready : initiator takes response
//   rsp_rdata  : load data (0 for stores and faults)
//   rsp_err    : misaligned or out-of-range access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic                 req_we,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [NUM_LANES-1:0] req_be,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q;
    logic                   we_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [NUM_LANES-1:0]   be_q;
    logic                   err_q;

    logic                   accept;
    logic                   enter_resp;
    logic [ADDR_W-1:0]      acc_addr;
    logic                   acc_we;
    logic [DATA_W-1:0]      acc_wdata;
    logic [NUM_LANES-1:0]   acc_be;
    logic                   acc_err;

    // Held low while reset is asserted even though the state register
    // already reads IDLE.
    assign req_ready = rst_n && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = err_q;

    // With zero wait states the access happens on the accept edge, so the
    // live request is used; otherwise the captured copy from WAIT.
    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state_q == IDLE) ? req_be    : be_q;

    assign acc_err = (|acc_addr[ADDR_LSB-1:0]) |
                     (|acc_addr[ADDR_W-1:IDX_W+ADDR_LSB]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (enter_resp) begin
                err_q <= acc_err;
            end
        end
    end

    dmem_ram_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (enter_resp),
        .we_i    (acc_we && !acc_err),
        .rd_i    (!acc_we && !acc_err),
        .be_i    (acc_be),
        .idx_i   (acc_addr[IDX_W+ADDR_LSB-1:ADDR_LSB]),
        .wdata_i (acc_wdata),
        .rdata_o (rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int LAT_A = 3;
    localparam int LAT_B = 0;
    localparam int LAT_C = 5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;
    int          sel;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic        c_req_ready, c_rsp_valid, c_rsp_err;
    logic [31:0] c_rsp_rdata;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 0), .req_ready(a_req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err));

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 1), .req_ready(b_req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(LAT_C)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 2), .req_ready(c_req_ready),
        .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(c_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err));

    always_comb begin
        req_ready = a_req_ready;
        rsp_valid = a_rsp_valid;
        rsp_rdata = a_rsp_rdata;
        rsp_err   = a_rsp_err;
        if (sel == 1) begin
            req_ready = b_req_ready;
            rsp_valid = b_rsp_valid;
            rsp_rdata = b_rsp_rdata;
            rsp_err   = b_rsp_err;
        end else if (sel == 2) begin
            req_ready = c_req_ready;
            rsp_valid = c_rsp_valid;
            rsp_rdata = c_rsp_rdata;
            rsp_err   = c_rsp_err;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        tbl[15];
    logic [31:0] model[1024];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    function automatic int cur_lat();
        if (sel == 1) return LAT_B;
        if (sel == 2) return LAT_C;
        return LAT_A;
    endfunction

    // Junk on the request bus while the responder is busy; must be ignored.
    task automatic garbage();
        req_valid = 1'b1;
        req_addr  = $urandom;
        req_we    = 1'($urandom_range(0, 1));
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                          input int hold);
        exp_t        e;
        exp_t        got;
        int          n;
        int          lat;
        logic [31:0] cap_d;
        logic        cap_e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = (hold == 0);
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        sb_q.push_back(e);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready=0 after %0d cycles, required 1", n);
            req_valid = 1'b0;
            void'(sb_q.pop_back());
            return;
        end
        @(posedge clk);
        @(negedge clk);
        garbage();
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            garbage();
        end
        if (!rsp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: got rsp_valid=0 after %0d cycles, required 1", lat);
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            void'(sb_q.pop_front());
            return;
        end
        chk("latency", 32'(lat), 32'(cur_lat() + 1));
        cap_d = rsp_rdata;
        cap_e = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            garbage();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, cap_d);
            chk("bp_err", 32'(rsp_err), 32'(cap_e));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        got = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, got.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(got.err));
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        $display("[TB] txn dut=%0d we=%0b addr=%08h wdata=%08h be=%h -> rdata=%08h err=%0b lat=%0d",
                 sel, we, addr, wdata, be, rsp_rdata, rsp_err, lat);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
    endtask

    // Drives one request, lets it reach RESP with rsp_ready low, then pulses
    // reset between clock edges and expects every output to drop at once.
    task automatic hold_then_reset(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = 4'hF;
        rsp_ready = 1'b0;
        chk("hr_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hr_reached_resp", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("async_rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("async_rst_req_ready", 32'(req_ready), 32'd0);
        $display("[TB] txn dut=%0d we=%0b addr=%08h aborted by reset in RESP", sel, we, addr);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("hr_ready_after_rst", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b1, 32'h0000_0080, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0080, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'hF, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0080, 32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0080, 32'h0000_0000, 4'hF, 32'hAA22_CC44, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0041, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        tbl[6]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
        tbl[7]  = '{1'b1, 32'h0000_0084, 32'h0BAD_F00D, 4'hF, 32'h0000_0000, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_0084, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
        tbl[9]  = '{1'b0, 32'h0000_0084, 32'h0000_0000, 4'h0, 32'h0BAD_F00D, 1'b0};
        tbl[10] = '{1'b1, 32'h0000_0FFC, 32'h1357_9BDF, 4'hF, 32'h0000_0000, 1'b0};
        tbl[11] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'hF, 32'h1357_9BDF, 1'b0};
        tbl[12] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        tbl[13] = '{1'b0, 32'h0000_0002, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        tbl[14] = '{1'b1, 32'h0000_0082, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        sel       = 0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(a_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(a_rsp_err), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready_a", 32'(a_req_ready), 32'd1);
        chk("post_rst_ready_b", 32'(b_req_ready), 32'd1);
        chk("post_rst_ready_c", 32'(c_req_ready), 32'd1);

        // LATENCY=0 responder: preload word 0x10, read it back, fault, backpressure.
        sel = 1;
        do_txn(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
        do_txn(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
        do_txn(1'b0, 32'h41, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        do_txn(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 3);

        // LATENCY=3 responder: fill every word with a known pattern.
        sel = 0;
        for (int i = 0; i < 1024; i++) begin
            model[i] = (32'(i) * 32'h9E37_79B1) ^ 32'hC3A5_0000;
            do_txn(1'b1, 32'(i) << 2, model[i], 4'hF, 32'h0, 1'b0, 0);
        end

        for (int k = 0; k < 15; k++) begin
            do_txn(tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].be,
                   tbl[k].exp_rdata, tbl[k].exp_err, 0);
            if (tbl[k].we && !tbl[k].exp_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (tbl[k].be[b]) begin
                        model[tbl[k].addr[11:2]][8*b +: 8] = tbl[k].wdata[8*b +: 8];
                    end
                end
            end
        end

        // Ten cycles of backpressure with junk requests on the bus.
        do_txn(1'b0, 32'h80, 32'h0, 4'h0, model[32], 1'b0, 10);

        // Faulting stores must not have touched any word.
        for (int i = 0; i < 1024; i++) begin
            do_txn(1'b0, 32'(i) << 2, 32'h0, 4'h0, model[i], 1'b0, 0);
        end

        // LATENCY=5 responder: reset in RESP and in WAIT.
        sel = 2;
        do_txn(1'b1, 32'h100, 32'h600D_CAFE, 4'hF, 32'h0, 1'b0, 0);
        hold_then_reset(1'b0, 32'h100, 32'h0);
        hold_then_reset(1'b1, 32'h104, 32'h0D15_EA5E);

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h100;
        req_wdata = 32'hCAFE_F00D;
        req_be    = 4'hF;
        rsp_ready = 1'b1;
        chk("mw_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mw_in_wait", 32'(rsp_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mw_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mw_rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("mw_rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("mw_rst_req_ready", 32'(req_ready), 32'd0);
        $display("[TB] txn dut=%0d we=1 addr=00000100 aborted by reset in WAIT", sel);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mw_ready_after_rst", 32'(req_ready), 32'd1);

        do_txn(1'b0, 32'h100, 32'h0, 4'h0, 32'h600D_CAFE, 1'b0, 0);
        do_txn(1'b0, 32'h104, 32'h0, 4'h0, 32'h0D15_EA5E, 1'b0, 0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
